// File: rtl/reaction_pkg.sv
// Shared types and constants for the reaction timer core.
// Holds the FSM state enum, BCD digit type and LFSR constants.
package reaction_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_GO,
        ST_DONE,
        ST_FOUL
    } state_t;

    typedef logic [3:0] bcd_digit_t;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    // Right-shifting Fibonacci form: taps 16,14,13,11 land on bits 0,2,3,5.
    localparam logic [15:0] LFSR_TAPS = 16'h002D;

    localparam bcd_digit_t BCD_MAX = 4'd9;

    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        logic [15:0] n;
        n = {^(v & LFSR_TAPS), v[15:1]};
        // Guard against the lock-up state if the register were ever corrupted.
        if (n == 16'h0000) begin
            n = LFSR_SEED;
        end
        return n;
    endfunction

endpackage

// File: rtl/reaction_timer_bcd_counter.sv
// Four-digit BCD incrementer that saturates at 9999.
// Clear has priority; freeze or saturation blocks counting.
module bcd_counter4
    import reaction_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       i_clear,
    input  logic       i_enable,
    input  logic       i_freeze,
    output logic [3:0] o_bcd3,
    output logic [3:0] o_bcd2,
    output logic [3:0] o_bcd1,
    output logic [3:0] o_bcd0,
    output logic       o_sat
);

    bcd_digit_t [3:0] r_d;
    bcd_digit_t [3:0] w_nxt;
    logic       [3:0] w_carry;
    logic             w_sat;

    // Ripple the +1 through the digits, wrapping each 9 back to 0.
    always_comb begin
        w_carry    = 4'b0000;
        w_nxt      = r_d;
        w_carry[0] = 1'b1;
        for (int i = 1; i < 4; i++) begin
            w_carry[i] = w_carry[i-1] && (r_d[i-1] == BCD_MAX);
        end
        for (int i = 0; i < 4; i++) begin
            if (w_carry[i]) begin
                if (r_d[i] == BCD_MAX) begin
                    w_nxt[i] = 4'd0;
                end else begin
                    w_nxt[i] = r_d[i] + 4'd1;
                end
            end
        end
    end

    assign w_sat = (r_d[3] == BCD_MAX) && (r_d[2] == BCD_MAX) &&
                   (r_d[1] == BCD_MAX) && (r_d[0] == BCD_MAX);

    // Digit registers: clear, then count when enabled and not held.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_d <= '0;
        end else if (i_clear) begin
            r_d <= '0;
        end else if (i_enable && !i_freeze && !w_sat) begin
            r_d <= w_nxt;
        end
    end

    assign o_bcd3 = r_d[3];
    assign o_bcd2 = r_d[2];
    assign o_bcd1 = r_d[1];
    assign o_bcd0 = r_d[0];
    assign o_sat  = w_sat;

endmodule

// File: rtl/reaction_timer_bcd.sv
// Reaction timer: random pre-go delay, then ms count in BCD until react.
// FSM, ms prescaler and LFSR live here; the digits live in bcd_counter4.
module reaction_timer_bcd
    import reaction_pkg::*;
#(
    parameter int TICK_DIV        = 50000,
    parameter int DELAY_MIN_MS    = 1000,
    parameter int DELAY_RAND_BITS = 11
)(
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       react,
    output logic [3:0] bcd3,
    output logic [3:0] bcd2,
    output logic [3:0] bcd1,
    output logic [3:0] bcd0,
    output logic       led_go,
    output logic       done,
    output logic       foul,
    output logic       overflow
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int DW = $clog2(DELAY_MIN_MS + (1 << DELAY_RAND_BITS) + 1);
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

    state_t          r_state;
    logic [PW-1:0]   r_presc;
    logic [DW-1:0]   r_delay;
    logic [15:0]     r_lfsr;
    logic            r_led_go;
    logic            r_done;
    logic            r_foul;
    logic            r_overflow;

    logic            w_run;
    logic            w_tick;
    logic            w_launch;
    logic            w_go_entry;
    logic [DW-1:0]   w_delay_init;
    logic            w_cnt_en;
    logic            w_freeze;
    logic            w_sat;

    // Prescaler only runs while waiting or counting.
    assign w_run  = (r_state == ST_WAIT) || (r_state == ST_GO);
    assign w_tick = w_run && (r_presc == PRE_LAST);

    // A start is honoured only from the resting states.
    assign w_launch = start &&
                      ((r_state == ST_IDLE) ||
                       (r_state == ST_DONE) ||
                       (r_state == ST_FOUL));

    // Final WAIT tick with no same-cycle react hands over to GO.
    assign w_go_entry = (r_state == ST_WAIT) && w_tick && !react &&
                        (r_delay <= DW'(1));

    assign w_delay_init = DW'(DELAY_MIN_MS) +
                          DW'(r_lfsr[DELAY_RAND_BITS-1:0]);

    // A react in the same cycle as a tick wins, so that tick is dropped.
    assign w_cnt_en = (r_state == ST_GO) && w_tick && !react;
    assign w_freeze = (r_state != ST_GO);

    // Free-running pseudo-random source, stepped every cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lfsr <= LFSR_SEED;
        end else begin
            r_lfsr <= lfsr_next(r_lfsr);
        end
    end

    // Millisecond prescaler, restarted on launch and on entry to GO.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_presc <= '0;
        end else if (w_launch || !w_run || w_go_entry || w_tick) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + PW'(1);
        end
    end

    // Main controller with registered status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_delay    <= '0;
            r_led_go   <= 1'b0;
            r_done     <= 1'b0;
            r_foul     <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            unique case (r_state)
                ST_IDLE, ST_DONE, ST_FOUL: begin
                    if (start) begin
                        r_state    <= ST_WAIT;
                        r_delay    <= w_delay_init;
                        r_led_go   <= 1'b0;
                        r_done     <= 1'b0;
                        r_foul     <= 1'b0;
                        r_overflow <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    if (react) begin
                        r_state <= ST_FOUL;
                        r_foul  <= 1'b1;
                    end else if (w_tick) begin
                        if (r_delay <= DW'(1)) begin
                            r_state  <= ST_GO;
                            r_delay  <= '0;
                            r_led_go <= 1'b1;
                        end else begin
                            r_delay <= r_delay - DW'(1);
                        end
                    end
                end
                ST_GO: begin
                    if (react) begin
                        r_state  <= ST_DONE;
                        r_led_go <= 1'b0;
                        r_done   <= 1'b1;
                    end else if (w_tick && w_sat) begin
                        r_state    <= ST_DONE;
                        r_led_go   <= 1'b0;
                        r_done     <= 1'b1;
                        r_overflow <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    bcd_counter4 u_count (
        .clk      (clk),
        .rst      (rst),
        .i_clear  (w_launch),
        .i_enable (w_cnt_en),
        .i_freeze (w_freeze),
        .o_bcd3   (bcd3),
        .o_bcd2   (bcd2),
        .o_bcd1   (bcd1),
        .o_bcd0   (bcd0),
        .o_sat    (w_sat)
    );

    assign led_go   = r_led_go;
    assign done     = r_done;
    assign foul     = r_foul;
    assign overflow = r_overflow;

endmodule

// File: tb/tb_reaction_timer_bcd.sv
// Directed and randomized bench for reaction_timer_bcd.
// Expected results come from ms arithmetic and an independent LFSR model.
module tb_reaction_timer_bcd;

    localparam int TD   = 4;
    localparam int DMIN = 2;
    localparam int DRB  = 2;

    logic       clk   = 1'b0;
    logic       rst   = 1'b1;
    logic       start = 1'b0;
    logic       react = 1'b0;
    logic [3:0] bcd3, bcd2, bcd1, bcd0;
    logic       led_go, done, foul, overflow;

    int total     = 0;
    int bad       = 0;
    int gcyc      = 0;
    int exp_delay = 0;
    int last_lat  = 0;
    int first_lat = 0;

    logic [15:0] m_lfsr;

    always #5 clk = ~clk;

    reaction_timer_bcd #(
        .TICK_DIV        (TD),
        .DELAY_MIN_MS    (DMIN),
        .DELAY_RAND_BITS (DRB)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .react    (react),
        .bcd3     (bcd3),
        .bcd2     (bcd2),
        .bcd1     (bcd1),
        .bcd0     (bcd0),
        .led_go   (led_go),
        .done     (done),
        .foul     (foul),
        .overflow (overflow)
    );

    // Reference pseudo-random sequence: x^16+x^14+x^13+x^11+1, seed ACE1.
    always @(posedge clk or posedge rst) begin
        if (rst) m_lfsr <= 16'hACE1;
        else     m_lfsr <= {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5],
                            m_lfsr[15:1]};
    end

    function automatic logic [15:0] to_bcd(input int n);
        logic [15:0] r;
        r[15:12] = 4'((n / 1000) % 10);
        r[11:8]  = 4'((n / 100) % 10);
        r[7:4]   = 4'((n / 10) % 10);
        r[3:0]   = 4'(n % 10);
        return r;
    endfunction

    // react driven k cycles into GO counts every whole ms before it.
    function automatic int ms_result(input int k);
        int r;
        r = k / TD;
        return (r > 9999) ? 9999 : r;
    endfunction

    function automatic logic [15:0] digits();
        return {bcd3, bcd2, bcd1, bcd0};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
        gcyc += n;
    endtask

    task automatic pulse_start();
        exp_delay = DMIN + int'(m_lfsr[DRB-1:0]);
        start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    task automatic pulse_react();
        react = 1'b1;
        step(1);
        react = 1'b0;
    endtask

    task automatic wait_go();
        int n;
        n = 0;
        while (led_go !== 1'b1 && n < 200) begin
            step(1);
            n++;
        end
        last_lat = n;
        chk("go_latency", n, TD * exp_delay);
        gcyc = 0;
    endtask

    initial begin
        int hi;
        int k;
        int j;

        // Reset state
        step(2);
        chk("rst_digits", digits(), 16'h0000);
        chk("rst_led_go", led_go, 0);
        chk("rst_done", done, 0);
        chk("rst_foul", foul, 0);
        chk("rst_ovf", overflow, 0);
        rst = 1'b0;
        step(3);

        // Normal run: react 10 ms after go
        pulse_start();
        chk("wait_no_go", led_go, 0);
        wait_go();
        first_lat = last_lat;
        step(40);
        pulse_react();
        chk("norm_done", done, 1);
        chk("norm_digits", digits(), to_bcd(ms_result(40)));
        chk("norm_led_off", led_go, 0);
        chk("norm_ovf", overflow, 0);
        step(100);
        chk("norm_hold", digits(), 16'h0010);
        chk("norm_hold_done", done, 1);

        // react while DONE is ignored
        pulse_react();
        step(3);
        chk("done_react_dig", digits(), 16'h0010);
        chk("done_react_done", done, 1);

        // Foul one cycle into WAIT
        pulse_start();
        chk("restart_done_clr", done, 0);
        chk("restart_dig_clr", digits(), 16'h0000);
        step(1);
        pulse_react();
        chk("foul_flag", foul, 1);
        chk("foul_digits", digits(), 16'h0000);
        chk("foul_done", done, 0);
        hi = 0;
        repeat (40) begin
            step(1);
            if (led_go !== 1'b0) hi++;
        end
        chk("foul_no_go", hi, 0);
        pulse_start();
        chk("foul_cleared", foul, 0);
        wait_go();

        // react coincident with 5th GO tick
        step(19);
        pulse_react();
        chk("react_on_tick", digits(), to_bcd(ms_result(19)));
        chk("react_on_tick_done", done, 1);

        // react coincident with final WAIT tick
        pulse_start();
        step(TD * exp_delay - 1);
        pulse_react();
        chk("last_wait_foul", foul, 1);
        chk("last_wait_no_go", led_go, 0);

        // start during GO is ignored
        pulse_start();
        wait_go();
        step(10);
        start = 1'b1;
        step(1);
        start = 1'b0;
        chk("go_start_ign", led_go, 1);
        step(30 - gcyc);
        pulse_react();
        chk("go_start_result", digits(), to_bcd(ms_result(30)));

        // Randomized runs
        for (int it = 0; it < 8; it++) begin
            pulse_start();
            if ($urandom_range(0, 1) == 1) begin
                j = $urandom_range(0, TD * exp_delay - 1);
                step(j);
                pulse_react();
                chk("rnd_foul", foul, 1);
                chk("rnd_foul_dig", digits(), 16'h0000);
                chk("rnd_foul_go", led_go, 0);
            end else begin
                wait_go();
                k = $urandom_range(0, 150);
                step(k);
                pulse_react();
                chk("rnd_result", digits(), to_bcd(ms_result(k)));
                chk("rnd_done", done, 1);
            end
        end

        // Full count to saturation
        pulse_start();
        wait_go();
        for (int t = 1; t <= 9999; t++) begin
            step(TD);
            if (t == 9 || t == 10 || t == 99 || t == 100 ||
                t == 999 || t == 1000 || t == 9999) begin
                chk($sformatf("carry_%0d", t), digits(), to_bcd(t));
            end
        end
        chk("pre_sat_ovf", overflow, 0);
        step(TD);
        chk("sat_digits", digits(), 16'h9999);
        chk("sat_ovf", overflow, 1);
        chk("sat_done", done, 1);
        chk("sat_led_off", led_go, 0);

        // Asynchronous reset mid-GO
        pulse_start();
        wait_go();
        step(12);
        chk("mid_go_count", digits(), to_bcd(3));
        #2 rst = 1'b1;
        #1;
        chk("arst_digits", digits(), 16'h0000);
        chk("arst_led_go", led_go, 0);
        chk("arst_done", done, 0);
        chk("arst_foul", foul, 0);
        chk("arst_ovf", overflow, 0);
        step(1);
        rst = 1'b0;
        step(3);
        pulse_start();
        wait_go();
        chk("same_delay", last_lat, first_lat);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
